// File: rtl/par2ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : par2ser_pkg
// Description : Shared types and constants for the parallel-to-serial
//               transmitter: FSM state encoding, default word width and a
//               frame-length helper.
// Options     : PAR2SER_PARITY_EN - append one even-parity bit to each frame.
// Revision    : 1.0 - initial release
// ============================================================================
package par2ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } par2ser_state_t;

  localparam int PAR2SER_WIDTH_DEF = 8;

  // Number of serial bits emitted per accepted word.
  function automatic int frame_len(input int width);
`ifdef PAR2SER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/par2ser_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : par2ser_hold_reg
// Description : One-word holding register in front of the shifter. Accepts a
//               word over valid/ready whenever it is empty and releases it
//               when the shifter loads it.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               din, din_valid  - upstream word and qualifier
//               load            - shifter consumes the held word this cycle
//               hold, hold_valid- held word and its full flag
//               din_ready       - register empty, may accept a word
// Revision    : 1.0 - initial release
// ============================================================================
module par2ser_hold_reg
  import par2ser_pkg::*;
#(
  parameter int WIDTH = PAR2SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             load,
  output logic [WIDTH-1:0] hold,
  output logic             hold_valid,
  output logic             din_ready
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             accept;

  // Ready only when empty, so a load (needs full) and an accept (needs
  // empty) can never coincide; a drained register refills one edge later.
  assign accept = din_valid & ~hold_valid_q;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_d       = din;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign hold       = hold_q;
  assign hold_valid = hold_valid_q;
  assign din_ready  = ~hold_valid_q;

endmodule
`default_nettype wire

// File: rtl/par2ser_tx.sv
`default_nettype none
// ============================================================================
// Module      : par2ser_tx
// Description : Parallel-to-serial transmitter. Words taken over valid/ready
//               are sent MSB first, one bit per clock; a holding register
//               lets consecutive frames run without idle cycles.
// Options     : PAR2SER_PARITY_EN - append the even parity of each word as
//               an extra frame bit (frame length WIDTH+1).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               din, din_valid      - parallel word input
//               din_ready           - a word may be accepted this cycle
//               bit_out, bit_valid  - serial stream (bit_out=0 when idle)
//               word_done           - high on the last bit of each frame
//               busy                - frame in flight or word held
// Revision    : 1.0 - initial release
// ============================================================================
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int WIDTH = PAR2SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  par2ser_state_t   state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             load;
  logic             last_bit;
`ifdef PAR2SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  par2ser_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .load       (load),
    .hold       (hold),
    .hold_valid (hold_valid),
    .din_ready  (din_ready)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef PAR2SER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        load = hold_valid;
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
`ifdef PAR2SER_PARITY_EN
          state_d = PARITY;
          cnt_d   = '0;
`else
          load    = hold_valid;
          state_d = IDLE;
          cnt_d   = '0;
`endif
        end
      end
`ifdef PAR2SER_PARITY_EN
      PARITY: begin
        load    = hold_valid;
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any frame boundary with a word waiting starts the next frame directly,
    // which overrides the fall-back to IDLE chosen above.
    if (load) begin
      state_d = SHIFT;
      shreg_d = hold;
      cnt_d   = '0;
`ifdef PAR2SER_PARITY_EN
      parity_d = ^hold;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PAR2SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PAR2SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs decode registered state only.
  assign bit_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE) | hold_valid;
`ifdef PAR2SER_PARITY_EN
  assign bit_out   = (state_q == SHIFT)  ? shreg_q[WIDTH-1] :
                     (state_q == PARITY) ? parity_q : 1'b0;
  assign word_done = (state_q == PARITY);
`else
  assign bit_out   = (state_q == SHIFT) & shreg_q[WIDTH-1];
  assign word_done = (state_q == SHIFT) & last_bit;
`endif

endmodule
`default_nettype wire
